// File: rtl/sti_load_sched.sv
// rtl/sti_load_sched.sv - command FIFO and load scheduler for STI_DAC; watchdog enabled by STI_SCHED_TIMEOUT_EN
module sti_load_sched #(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [4:0]  wr_cfg,
  input  logic        wr_last,
  output logic        full,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic        timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO_CYC) + 1;

`ifdef STI_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_END,
    S_DONE
  } state_t;

  state_t state, next_state;

  // FIFO entry layout: {last, len[1:0], fill, msb, low, data[15:0]}
  logic [21:0]   mem [DEPTH];
  logic [21:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic          len_chk, tmo_fire, tmo_hit;
  logic [5:0]    bit_cnt, exp_bits;
  logic [TW-1:0] wdog;

  // DONE reports full so late pushes are refused at the port
  assign full     = (count == CW'(DEPTH)) || (state == S_DONE);
  assign push     = wr_en && !full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign head     = mem[rd_ptr];
  assign load     = (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE) || (count != '0);
  assign exp_bits = {1'b0, pi_length, 3'b000} + 6'd8;
  assign tmo_hit  = TMO_ON && (wdog == TW'(TMO_CYC - 1));

  // FIFO storage; occupancy lives in count, so storage needs no reset
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= {wr_last, wr_cfg, wr_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // next-state logic and per-cycle check strobes
  always_comb begin
    next_state = state;
    len_chk    = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) next_state = S_LOAD;
      end
      S_LOAD: begin
        next_state = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (so_valid) begin
          next_state = S_WAIT_END;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          next_state = pi_end ? S_DONE : S_IDLE;
        end
      end
      S_WAIT_END: begin
        if (!so_valid) begin
          len_chk    = 1'b1;
          next_state = pi_end ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        next_state = S_DONE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // output registers, bit counter, watchdog and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_data     <= '0;
      pi_length   <= '0;
      pi_fill     <= 1'b0;
      pi_msb      <= 1'b0;
      pi_low      <= 1'b0;
      pi_end      <= 1'b0;
      bit_cnt     <= '0;
      wdog        <= '0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) begin
        pi_data   <= head[15:0];
        pi_low    <= head[16];
        pi_msb    <= head[17];
        pi_fill   <= head[18];
        pi_length <= head[20:19];
        pi_end    <= head[21];
      end
      if (state == S_LOAD) begin
        wdog <= '0;
      end else if (state == S_WAIT_START && !so_valid) begin
        wdog <= wdog + 1'b1;
      end
      if (state == S_WAIT_START && so_valid) begin
        bit_cnt <= 6'd1;
      end else if (state == S_WAIT_END && so_valid && bit_cnt != 6'd63) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (len_chk && (bit_cnt != exp_bits)) len_err <= 1'b1;
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sti_load_sched.sv
// tb/tb_sti_load_sched.sv - self-checking bench for sti_load_sched
module tb_sti_load_sched;

  localparam int DEPTH   = 4;
  localparam int TMO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_last, so_valid;
  logic [15:0] wr_data;
  logic [4:0]  wr_cfg;
  logic        full, load, pi_fill, pi_msb, pi_low, pi_end, busy, done, len_err, timeout_err;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  cfg;
    int          nbits;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  cfg;
  } ent_t;

  vec_t vecs [8];
  ent_t q [$];

  sti_load_sched #(.DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_cfg(wr_cfg),
    .wr_last(wr_last), .full(full), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .busy(busy), .done(done), .len_err(len_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // count load strobes mid-cycle
  always @(negedge clk) if (load === 1'b1) load_cnt++;

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; so_valid = 1'b0;
    wr_data = '0; wr_cfg = '0; wr_last = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic [4:0] c, input logic l);
    wr_en = 1'b1; wr_data = d; wr_cfg = c; wr_last = l;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_load(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // STI_DAC stand-in: so_valid high for n sampled cycles, then low; call while in WAIT_START
  task automatic serve(input int n);
    so_valid = 1'b1;
    repeat (n) tick();
    so_valid = 1'b0;
    tick();
  endtask

  function automatic int exp_len(input logic [4:0] c);
    return (int'(c[4:3]) + 1) * 8;
  endfunction

  function automatic int pick_bits(input logic [4:0] c);
    int d = int'($urandom_range(0, 3));
    if (d == 2) return exp_len(c) - 1;
    if (d == 3) return exp_len(c) + 1;
    return exp_len(c);
  endfunction

  initial begin
    int base, base2, k, nb;
    bit model_err;
    ent_t e;

    // reset state
    do_reset();
    check("rst_load", 32'(load), 0);
    check("rst_pi_data", 32'(pi_data), 0);
    check("rst_cfg", 32'({pi_length, pi_fill, pi_msb, pi_low}), 0);
    check("rst_flags", 32'({pi_end, done, len_err, timeout_err}), 0);
    check("rst_busy_full", 32'({busy, full}), 0);

    // single-entry length table
    vecs[0] = '{16'h0F0F, 5'b00101, 8,  1'b0};
    vecs[1] = '{16'hA5C3, 5'b01010, 16, 1'b0};
    vecs[2] = '{16'h8001, 5'b10111, 24, 1'b0};
    vecs[3] = '{16'hFFFF, 5'b11000, 32, 1'b0};
    vecs[4] = '{16'h1357, 5'b00011, 9,  1'b1};
    vecs[5] = '{16'h2468, 5'b11100, 31, 1'b1};
    vecs[6] = '{16'hC0DE, 5'b00001, 72, 1'b1};
    vecs[7] = '{16'h7E7E, 5'b10110, 25, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      push(vecs[i].data, vecs[i].cfg, 1'b0);
      wait_load($sformatf("vec%0d_load", i));
      check($sformatf("vec%0d_data", i), 32'(pi_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_cfg", i), 32'({pi_length, pi_fill, pi_msb, pi_low}), 32'(vecs[i].cfg));
      tick();
      serve(vecs[i].nbits);
      check($sformatf("vec%0d_len_err", i), 32'(len_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_idle", i), 32'({busy, done}), 0);
    end

    // single last entry, then a push in DONE
    do_reset();
    base = load_cnt;
    push(16'hA5C3, 5'b01000, 1'b1);
    wait_load("single_load");
    check("single_data", 32'(pi_data), 32'hA5C3);
    check("single_end", 32'(pi_end), 1);
    check("single_len", 32'(pi_length), 1);
    tick();
    serve(16);
    tick();
    check("single_done", 32'(done), 1);
    check("single_len_err", 32'(len_err), 0);
    check("single_pulses", 32'(load_cnt - base), 1);
    push(16'h1234, 5'b00000, 1'b0);
    check("done_full", 32'(full), 1);
    repeat (5) tick();
    check("done_no_load", 32'(load_cnt - base), 1);
    check("done_held", 32'({done, pi_end}), 32'b11);
    check("done_pi_hold", 32'(pi_data), 32'hA5C3);

    // fill and drain behind a blocked entry
    do_reset();
    base = load_cnt;
    push(16'hBEEF, 5'b00000, 1'b0);
    wait_load("fill_blk_load");
    for (int j = 0; j < 5; j++) begin
      push(16'h1000 + 16'(j), 5'(j), 1'b0);
      check($sformatf("fill_full%0d", j), 32'(full), (j >= 3) ? 1 : 0);
    end
    serve(8);
    for (int j = 0; j < 4; j++) begin
      wait_load($sformatf("drain%0d_load", j));
      check($sformatf("drain%0d_data", j), 32'(pi_data), 32'h1000 + j);
      tick();
      serve(8);
    end
    repeat (10) tick();
    check("drain_pulses", 32'(load_cnt - base), 5);
    check("drain_idle", 32'({busy, len_err}), 0);

    // sticky length error
    do_reset();
    push(16'h3C3C, 5'b10010, 1'b0);
    wait_load("lenerr_load");
    tick();
    serve(23);
    check("lenerr_set", 32'(len_err), 1);
    push(16'h00FF, 5'b00001, 1'b0);
    wait_load("lenerr_next_load");
    check("lenerr_next_data", 32'(pi_data), 32'h00FF);
    tick();
    serve(8);
    check("lenerr_sticky", 32'(len_err), 1);
    check("lenerr_idle", 32'(busy), 0);

    // watchdog
    do_reset();
    base = load_cnt;
    push(16'h5555, 5'b00000, 1'b0);
    wait_load("wd_load");
`ifdef STI_SCHED_TIMEOUT_EN
    repeat (16) tick();
    check("wd_not_yet", 32'(timeout_err), 0);
    tick();
    check("wd_fired", 32'(timeout_err), 1);
    push(16'h6666, 5'b00000, 1'b0);
    wait_load("wd_next_load");
    check("wd_next_data", 32'(pi_data), 32'h6666);
    tick();
    serve(8);
    check("wd_sticky", 32'({timeout_err, len_err}), 32'b10);
`else
    push(16'h6666, 5'b00000, 1'b0);
    repeat (30) tick();
    check("wd_off_err", 32'(timeout_err), 0);
    check("wd_off_busy", 32'(busy), 1);
    check("wd_off_no_load", 32'(load_cnt - base), 1);
`endif

    // reset during WAIT_END with two queued entries
    do_reset();
    push(16'h1111, 5'b01000, 1'b0);
    wait_load("rstmid_load");
    push(16'h2222, 5'b00000, 1'b0);
    push(16'h3333, 5'b00000, 1'b0);
    so_valid = 1'b1;
    repeat (3) tick();
    reset = 1'b1; wr_en = 1'b1; wr_data = 16'h4444;
    tick();
    reset = 1'b0; wr_en = 1'b0; so_valid = 1'b0;
    check("rstmid_pi", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 0);
    check("rstmid_flags", 32'({load, pi_end, done, len_err, timeout_err, busy, full}), 0);
    base2 = load_cnt;
    repeat (10) tick();
    check("rstmid_no_load", 32'(load_cnt - base2), 0);
    check("rstmid_idle", 32'(busy), 0);
    push(16'h5A5A, 5'b00000, 1'b0);
    wait_load("rstmid_new_load");
    check("rstmid_new_data", 32'(pi_data), 32'h5A5A);

    // randomized rounds against a queue model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      q.delete();
      model_err = 1'b0;
      base = load_cnt;
      e.data = 16'($urandom);
      e.cfg  = 5'($urandom);
      push(e.data, e.cfg, 1'b0);
      wait_load($sformatf("rnd%0d_blk_load", r));
      check($sformatf("rnd%0d_blk_data", r), 32'(pi_data), 32'(e.data));
      k = int'($urandom_range(1, DEPTH + 2));
      base2 = 0;
      for (int j = 0; j < k; j++) begin
        ent_t n;
        n.data = 16'($urandom);
        n.cfg  = 5'($urandom);
        push(n.data, n.cfg, 1'b0);
        if (q.size() < DEPTH) begin
          q.push_back(n);
          base2++;
        end
        check($sformatf("rnd%0d_full%0d", r, j), 32'(full), 32'(q.size() == DEPTH));
      end
      nb = pick_bits(e.cfg);
      if (nb != exp_len(e.cfg)) model_err = 1'b1;
      serve(nb);
      while (q.size() > 0) begin
        e = q.pop_front();
        wait_load($sformatf("rnd%0d_load", r));
        check($sformatf("rnd%0d_data", r), 32'(pi_data), 32'(e.data));
        check($sformatf("rnd%0d_cfg", r), 32'({pi_length, pi_fill, pi_msb, pi_low}), 32'(e.cfg));
        tick();
        nb = pick_bits(e.cfg);
        if (nb != exp_len(e.cfg)) model_err = 1'b1;
        serve(nb);
      end
      tick();
      check($sformatf("rnd%0d_len_err", r), 32'(len_err), 32'(model_err));
      check($sformatf("rnd%0d_idle", r), 32'(busy), 0);
      check($sformatf("rnd%0d_pulses", r), 32'(load_cnt - base), 32'(1 + base2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
